// File: rtl/avmm_cmd_pkg.sv
// Shared types and widths for the Avalon-MM command master.
package avmm_cmd_pkg;

    localparam int unsigned CMD_ADDR_W = 4;
    localparam int unsigned CMD_DATA_W = 32;
    localparam int unsigned LAT_W      = 2;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RDWAIT,
        RESP
    } state_t;

    typedef struct packed {
        logic                  write;
        logic [CMD_ADDR_W-1:0] address;
        logic [CMD_DATA_W-1:0] wdata;
    } cmd_t;

    // Counter width able to hold n; a disabled (zero) limit still needs one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n == 0) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/avmm_cmd_master_if.sv
// Command stream, response stream and Avalon-MM bus signals of avmm_cmd_master.
interface avmm_cmd_master_if
    import avmm_cmd_pkg::*;
#(
    parameter int unsigned ADDR_W = CMD_ADDR_W,
    parameter int unsigned DATA_W = CMD_DATA_W
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_address;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_write;
    logic              rsp_timeout;
    logic [ADDR_W-1:0] avm_address;
    logic              avm_chipselect;
    logic              avm_write_n;
    logic              avm_read_n;
    logic [DATA_W-1:0] avm_writedata;
    logic [DATA_W-1:0] avm_readdata;
    logic              avm_waitrequest;

    modport master (
        input  cmd_valid, cmd_write, cmd_address, cmd_wdata, rsp_ready,
               avm_readdata, avm_waitrequest,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_write, rsp_timeout,
               avm_address, avm_chipselect, avm_write_n, avm_read_n, avm_writedata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_address, cmd_wdata, rsp_ready,
               avm_readdata, avm_waitrequest,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_write, rsp_timeout,
               avm_address, avm_chipselect, avm_write_n, avm_read_n, avm_writedata
    );
endinterface

// File: rtl/avmm_cmd_fifo.sv
// Synchronous command FIFO with full/empty flags; pointers carry a wrap bit.
module avmm_cmd_fifo
    import avmm_cmd_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic push_i,
    input  cmd_t din_i,
    output logic full_o,
    input  logic pop_i,
    output cmd_t dout_o,
    output logic empty_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    cmd_t             mem_q [DEPTH];
    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign dout_o  = mem_q[rd_ptr_q[PTR_W-1:0]];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= din_i;
    end
endmodule

// File: rtl/avmm_cmd_master.sv
// Avalon-MM initiator: issues buffered commands one at a time and returns read/timeout responses.
module avmm_cmd_master
    import avmm_cmd_pkg::*;
#(
    parameter int unsigned ADDR_W       = CMD_ADDR_W,
    parameter int unsigned DATA_W       = CMD_DATA_W,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned READ_LATENCY = 0,
    parameter int unsigned TIMEOUT      = 255
) (
    input logic clk,
    input logic reset_n,
    avmm_cmd_master_if.master bus
);
    localparam int unsigned TMO_W = cnt_w(TIMEOUT);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              cs_q, cs_d;
    logic              wr_n_q, wr_n_d;
    logic              rd_n_q, rd_n_d;
    logic              write_q, write_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rsp_write_q, rsp_write_d;
    logic              rsp_tmo_q, rsp_tmo_d;

    cmd_t push_cmd, pop_cmd;
    logic fifo_full, fifo_empty, pop;

    assign push_cmd = '{write:   bus.cmd_write,
                        address: CMD_ADDR_W'(bus.cmd_address),
                        wdata:   CMD_DATA_W'(bus.cmd_wdata)};

    avmm_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (bus.cmd_valid),
        .din_i   (push_cmd),
        .full_o  (fifo_full),
        .pop_i   (pop),
        .dout_o  (pop_cmd),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cs_d        = cs_q;
        wr_n_d      = wr_n_q;
        rd_n_d      = rd_n_q;
        write_d     = write_q;
        tmo_d       = tmo_q;
        lat_d       = lat_q;
        rdata_d     = rdata_q;
        rsp_write_d = rsp_write_q;
        rsp_tmo_d   = rsp_tmo_q;
        pop         = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    addr_d  = ADDR_W'(pop_cmd.address);
                    wdata_d = DATA_W'(pop_cmd.wdata);
                    write_d = pop_cmd.write;
                    cs_d    = 1'b1;
                    wr_n_d  = !pop_cmd.write;
                    rd_n_d  = pop_cmd.write;
                    tmo_d   = '0;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (!bus.avm_waitrequest) begin
                    cs_d   = 1'b0;
                    wr_n_d = 1'b1;
                    rd_n_d = 1'b1;
                    if (write_q) begin
                        state_d = IDLE;
                    end else if (READ_LATENCY == 0) begin
                        rdata_d     = bus.avm_readdata;
                        rsp_write_d = 1'b0;
                        rsp_tmo_d   = 1'b0;
                        state_d     = RESP;
                    end else begin
                        lat_d   = '0;
                        state_d = RDWAIT;
                    end
                end else if (TIMEOUT != 0 && tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    // This cycle is the TIMEOUT-th stalled one, so the strobe was high exactly TIMEOUT cycles.
                    cs_d        = 1'b0;
                    wr_n_d      = 1'b1;
                    rd_n_d      = 1'b1;
                    rdata_d     = '0;
                    rsp_write_d = write_q;
                    rsp_tmo_d   = 1'b1;
                    state_d     = RESP;
                end else if (tmo_q != '1) begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            RDWAIT: begin
                if (lat_q == LAT_W'(READ_LATENCY - 1)) begin
                    rdata_d     = bus.avm_readdata;
                    rsp_write_d = 1'b0;
                    rsp_tmo_d   = 1'b0;
                    state_d     = RESP;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            cs_q        <= 1'b0;
            wr_n_q      <= 1'b1;
            rd_n_q      <= 1'b1;
            write_q     <= 1'b0;
            tmo_q       <= '0;
            lat_q       <= '0;
            rdata_q     <= '0;
            rsp_write_q <= 1'b0;
            rsp_tmo_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cs_q        <= cs_d;
            wr_n_q      <= wr_n_d;
            rd_n_q      <= rd_n_d;
            write_q     <= write_d;
            tmo_q       <= tmo_d;
            lat_q       <= lat_d;
            rdata_q     <= rdata_d;
            rsp_write_q <= rsp_write_d;
            rsp_tmo_q   <= rsp_tmo_d;
        end
    end

    assign bus.cmd_ready      = !fifo_full;
    assign bus.avm_address    = addr_q;
    assign bus.avm_writedata  = wdata_q;
    assign bus.avm_chipselect = cs_q;
    assign bus.avm_write_n    = wr_n_q;
    assign bus.avm_read_n     = rd_n_q;
    assign bus.rsp_valid      = (state_q == RESP);
    assign bus.rsp_rdata      = rdata_q;
    assign bus.rsp_write      = rsp_write_q;
    assign bus.rsp_timeout    = rsp_tmo_q;
endmodule

// File: tb/tb_avmm_cmd_master.sv
// Directed bench for avmm_cmd_master against a 16-word PIO slave model.
module tb_avmm_cmd_master;
    localparam int unsigned AW = 4;
    localparam int unsigned DW = 32;

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   passed = 0;
    int   wr_count;
    logic [DW-1:0] mem [16];

    avmm_cmd_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    avmm_cmd_master #(
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .FIFO_DEPTH   (4),
        .READ_LATENCY (0),
        .TIMEOUT      (8)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // PIO slave: zero-latency reads, writes land on a non-stalled write strobe.
    always @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
            wr_count <= 0;
        end else if (bus.avm_chipselect && !bus.avm_write_n && !bus.avm_waitrequest) begin
            mem[bus.avm_address] <= bus.avm_writedata;
            wr_count <= wr_count + 1;
        end
    end

    always_comb bus.avm_readdata = mem[bus.avm_address];

    task automatic drive_cmd(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.cmd_valid   = 1'b1;
        bus.cmd_write   = w;
        bus.cmd_address = a;
        bus.cmd_wdata   = d;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_address = '0; bus.cmd_wdata = '0;
        bus.rsp_ready = 1'b1; bus.avm_waitrequest = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.avm_chipselect !== 1'b0) $display("FAIL rst_cs got=%b exp=0", bus.avm_chipselect); else passed++;
        checks++; if (bus.avm_write_n !== 1'b1) $display("FAIL rst_write_n got=%b exp=1", bus.avm_write_n); else passed++;
        checks++; if (bus.avm_read_n !== 1'b1) $display("FAIL rst_read_n got=%b exp=1", bus.avm_read_n); else passed++;
        checks++; if (bus.avm_address !== 4'd0) $display("FAIL rst_addr got=%h exp=0", bus.avm_address); else passed++;
        checks++; if (bus.avm_writedata !== 32'd0) $display("FAIL rst_wdata got=%h exp=0", bus.avm_writedata); else passed++;
        checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid got=%b exp=0", bus.rsp_valid); else passed++;
        checks++; if (bus.rsp_rdata !== 32'd0) $display("FAIL rst_rsp_rdata got=%h exp=0", bus.rsp_rdata); else passed++;
        checks++; if (bus.rsp_write !== 1'b0) $display("FAIL rst_rsp_write got=%b exp=0", bus.rsp_write); else passed++;
        checks++; if (bus.rsp_timeout !== 1'b0) $display("FAIL rst_rsp_timeout got=%b exp=0", bus.rsp_timeout); else passed++;
        checks++; if (bus.cmd_ready !== 1'b1) $display("FAIL rst_cmd_ready got=%b exp=1", bus.cmd_ready); else passed++;
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write();
        drive_cmd(1'b1, 4'd0, 32'h1);
        checks++; if (bus.cmd_ready !== 1'b1) $display("FAIL wr_accept got=%b exp=1", bus.cmd_ready); else passed++;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        checks++; if (bus.avm_chipselect !== 1'b0) $display("FAIL wr_t1_cs got=%b exp=0", bus.avm_chipselect); else passed++;
        @(negedge clk);
        checks++; if (bus.avm_chipselect !== 1'b1) $display("FAIL wr_t2_cs got=%b exp=1", bus.avm_chipselect); else passed++;
        checks++; if (bus.avm_write_n !== 1'b0) $display("FAIL wr_t2_write_n got=%b exp=0", bus.avm_write_n); else passed++;
        checks++; if (bus.avm_read_n !== 1'b1) $display("FAIL wr_t2_read_n got=%b exp=1", bus.avm_read_n); else passed++;
        checks++; if (bus.avm_writedata !== 32'h1) $display("FAIL wr_t2_wdata got=%h exp=1", bus.avm_writedata); else passed++;
        @(negedge clk);
        checks++; if (bus.avm_chipselect !== 1'b0 || bus.avm_write_n !== 1'b1) $display("FAIL wr_t3_strobe got=%b%b exp=01", bus.avm_chipselect, bus.avm_write_n); else passed++;
        checks++; if (mem[0] !== 32'h1) $display("FAIL wr_slave_data got=%h exp=1", mem[0]); else passed++;
        checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL wr_no_rsp got=%b exp=0", bus.rsp_valid); else passed++;
        @(negedge clk);
        checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL wr_no_rsp2 got=%b exp=0", bus.rsp_valid); else passed++;
        checks++; if (wr_count !== 1) $display("FAIL wr_count got=%0d exp=1", wr_count); else passed++;
    endtask

    task automatic test_read();
        drive_cmd(1'b0, 4'd0, 32'h0);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        checks++; if (bus.avm_chipselect !== 1'b1 || bus.avm_read_n !== 1'b0 || bus.avm_write_n !== 1'b1)
            $display("FAIL rd_t2_strobe got=%b%b%b exp=101", bus.avm_chipselect, bus.avm_read_n, bus.avm_write_n); else passed++;
        checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL rd_t2_rsp got=%b exp=0", bus.rsp_valid); else passed++;
        @(negedge clk);
        checks++; if (bus.rsp_valid !== 1'b1) $display("FAIL rd_t3_rsp_valid got=%b exp=1", bus.rsp_valid); else passed++;
        checks++; if (bus.rsp_rdata !== 32'h1) $display("FAIL rd_t3_rdata got=%h exp=00000001", bus.rsp_rdata); else passed++;
        checks++; if (bus.rsp_timeout !== 1'b0) $display("FAIL rd_t3_timeout got=%b exp=0", bus.rsp_timeout); else passed++;
        checks++; if (bus.avm_chipselect !== 1'b0) $display("FAIL rd_t3_cs got=%b exp=0", bus.avm_chipselect); else passed++;
        @(negedge clk);
        checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL rd_rsp_drop got=%b exp=0", bus.rsp_valid); else passed++;
        drive_cmd(1'b0, 4'd1, 32'h0);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'h0)
            $display("FAIL rd_addr1 got=%b/%h exp=1/00000000", bus.rsp_valid, bus.rsp_rdata); else passed++;
        @(negedge clk);
    endtask

    task automatic test_waitrequest();
        int base;
        base = wr_count;
        bus.avm_waitrequest = 1'b1;
        drive_cmd(1'b1, 4'd2, 32'hA5);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if ({bus.avm_chipselect, bus.avm_write_n, bus.avm_read_n, bus.avm_address, bus.avm_writedata} !== {1'b1, 1'b0, 1'b1, 4'd2, 32'hA5})
                $display("FAIL wait_hold%0d got=%b%b%b/%h/%h exp=101/2/000000a5", i, bus.avm_chipselect, bus.avm_write_n, bus.avm_read_n, bus.avm_address, bus.avm_writedata);
            else passed++;
            if (i == 3) bus.avm_waitrequest = 1'b0;
        end
        @(negedge clk);
        checks++; if (bus.avm_chipselect !== 1'b0) $display("FAIL wait_release_cs got=%b exp=0", bus.avm_chipselect); else passed++;
        checks++; if (mem[2] !== 32'hA5) $display("FAIL wait_slave_data got=%h exp=a5", mem[2]); else passed++;
        checks++; if (wr_count !== base + 1) $display("FAIL wait_write_count got=%0d exp=%0d", wr_count, base + 1); else passed++;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int   hi;
        logic seen;
        logic found;
        hi = 0; seen = 1'b0; found = 1'b0;
        bus.avm_waitrequest = 1'b1;
        drive_cmd(1'b0, 4'd0, 32'h0);
        @(negedge clk);
        drive_cmd(1'b1, 4'd3, 32'h5A);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (bus.avm_chipselect && !bus.avm_read_n) hi++;
            if (bus.rsp_valid) seen = 1'b1;
            else @(negedge clk);
        end
        checks++; if (seen !== 1'b1) $display("FAIL tmo_rsp_seen got=%b exp=1", seen); else passed++;
        checks++; if (hi !== 8) $display("FAIL tmo_strobe_cycles got=%0d exp=8", hi); else passed++;
        checks++; if (bus.rsp_timeout !== 1'b1) $display("FAIL tmo_flag got=%b exp=1", bus.rsp_timeout); else passed++;
        checks++; if (bus.rsp_rdata !== 32'h0) $display("FAIL tmo_rdata got=%h exp=0", bus.rsp_rdata); else passed++;
        checks++; if (bus.rsp_write !== 1'b0) $display("FAIL tmo_rsp_write got=%b exp=0", bus.rsp_write); else passed++;
        bus.avm_waitrequest = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (bus.avm_chipselect && !bus.avm_write_n) found = 1'b1;
        end
        checks++; if (found !== 1'b1) $display("FAIL tmo_next_issue got=%b exp=1", found); else passed++;
        checks++; if (bus.avm_address !== 4'd3 || bus.avm_writedata !== 32'h5A)
            $display("FAIL tmo_next_cmd got=%h/%h exp=3/0000005a", bus.avm_address, bus.avm_writedata); else passed++;
        @(negedge clk);
        checks++; if (mem[3] !== 32'h5A) $display("FAIL tmo_next_data got=%h exp=5a", mem[3]); else passed++;
        checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL tmo_next_no_rsp got=%b exp=0", bus.rsp_valid); else passed++;
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [AW-1:0] addrs [6];
        logic [DW-1:0] exp_rd [6];
        int   idx, acc, nr;
        logic pend;
        addrs  = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0, 4'd2};
        exp_rd = '{32'h1, 32'h0, 32'hA5, 32'h5A, 32'h1, 32'hA5};
        idx = 0; acc = 0; nr = 0; pend = 1'b0;
        bus.rsp_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (pend) begin idx++; pend = 1'b0; end
            if (idx < 6) begin
                drive_cmd(1'b0, addrs[idx], 32'h0);
                if (bus.cmd_ready) begin pend = 1'b1; acc++; end
            end else bus.cmd_valid = 1'b0;
            @(negedge clk);
        end
        checks++; if (acc !== 5) $display("FAIL bp_accepts got=%0d exp=5", acc); else passed++;
        checks++; if (bus.cmd_ready !== 1'b0) $display("FAIL bp_full_ready got=%b exp=0", bus.cmd_ready); else passed++;
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'h1)
            $display("FAIL bp_held_rsp got=%b/%h exp=1/00000001", bus.rsp_valid, bus.rsp_rdata); else passed++;
        bus.rsp_ready = 1'b1;
        for (int c = 0; c < 40 && nr < 6; c++) begin
            if (pend) begin idx++; pend = 1'b0; end
            if (idx < 6) begin
                drive_cmd(1'b0, addrs[idx], 32'h0);
                if (bus.cmd_ready) begin pend = 1'b1; acc++; end
            end else bus.cmd_valid = 1'b0;
            if (bus.rsp_valid) begin
                checks++; if (bus.rsp_rdata !== exp_rd[nr]) $display("FAIL bp_rsp%0d got=%h exp=%h", nr, bus.rsp_rdata, exp_rd[nr]); else passed++;
                nr++;
            end
            @(negedge clk);
        end
        bus.cmd_valid = 1'b0;
        checks++; if (nr !== 6) $display("FAIL bp_rsp_count got=%0d exp=6", nr); else passed++;
        checks++; if (acc !== 6) $display("FAIL bp_total_accepts got=%0d exp=6", acc); else passed++;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_midop();
        int act;
        act = 0;
        bus.avm_waitrequest = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_cmd(1'b1, AW'(5 + i), 32'hC0 + i);
            @(negedge clk);
        end
        bus.cmd_valid = 1'b0;
        checks++; if (bus.avm_chipselect !== 1'b1) $display("FAIL mid_in_access got=%b exp=1", bus.avm_chipselect); else passed++;
        #1 reset_n = 1'b0;
        #1;
        checks++; if (bus.avm_chipselect !== 1'b0 || bus.avm_write_n !== 1'b1 || bus.avm_read_n !== 1'b1)
            $display("FAIL mid_rst_strobes got=%b%b%b exp=011", bus.avm_chipselect, bus.avm_write_n, bus.avm_read_n); else passed++;
        checks++; if (bus.cmd_ready !== 1'b1) $display("FAIL mid_rst_ready got=%b exp=1", bus.cmd_ready); else passed++;
        checks++; if (bus.avm_address !== 4'd0) $display("FAIL mid_rst_addr got=%h exp=0", bus.avm_address); else passed++;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        bus.avm_waitrequest = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.avm_chipselect || bus.rsp_valid) act++;
        end
        checks++; if (act !== 0) $display("FAIL mid_post_activity got=%0d exp=0", act); else passed++;
        checks++; if (wr_count !== 0) $display("FAIL mid_post_writes got=%0d exp=0", wr_count); else passed++;
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_waitrequest();
        test_timeout();
        test_backpressure();
        test_reset_midop();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
